// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer: FSM state encoding,
// measurement width and LFSR (x^10 + x^7 + 1) taps.
package reaction_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_LIGHT  = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  localparam int MS_W        = 14;
  localparam int LFSR_W      = 10;
  localparam int LFSR_TAP_HI = 9;
  localparam int LFSR_TAP_LO = 6;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 10'h3FF;

  // Fibonacci form: feedback from bits 10 and 7 (1-based) shifts in at bit 0
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_DIV-1 and flags tick on the last count.
// clear restarts the count so the next tick lands TICK_DIV cycles later.
module ms_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear || tick) r_cnt <= '0;
    else                        r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-time game controller: random delay, stimulus LED, ms measurement.
// Optional REACTION_BEST_SCORE_EN adds a best_ms output tracking the fastest result.
module reaction_timer_ctrl
  import reaction_pkg::*;
#(
  parameter int                TICK_DIV   = 50000,
  parameter int                DELAY_MIN  = 1000,
  parameter logic [LFSR_W-1:0] DELAY_MASK = 10'h3FF,
  parameter int                MAX_MS     = 9999
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stop,
  output logic            led,
  output logic [MS_W-1:0] time_ms,
  output logic            time_valid,
  output logic            early,
  output logic            timeout,
  output logic            busy
`ifdef REACTION_BEST_SCORE_EN
  , output logic [MS_W-1:0] best_ms
`endif
);

  localparam logic [MS_W-1:0] MAX_MS_W = MS_W'(MAX_MS);

  state_t            r_state;
  logic [LFSR_W-1:0] r_lfsr;
  logic [MS_W-1:0]   r_delay;
  logic [MS_W-1:0]   r_count;
  logic [MS_W-1:0]   r_time_ms;
  logic              r_led, r_time_valid, r_early, r_timeout, r_busy;

  logic              w_tick, w_clear, w_cap_en, w_delay_done;
  logic [MS_W-1:0]   w_delay_load;

  assign w_delay_load = MS_W'(DELAY_MIN) + MS_W'(r_lfsr & DELAY_MASK);
  assign w_delay_done = (r_delay < MS_W'(2));
  assign w_cap_en     = (r_state == ST_LIGHT) && stop;

  // Prescaler restarts on the same edge that enters WAIT or LIGHT
  always_comb begin
    w_clear = 1'b0;
    case (r_state)
      ST_IDLE, ST_RESULT: w_clear = start;
      ST_WAIT:            w_clear = !stop && w_tick && w_delay_done;
      default:            w_clear = 1'b0;
    endcase
  end

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_lfsr       <= LFSR_SEED;
      r_delay      <= '0;
      r_count      <= '0;
      r_time_ms    <= '0;
      r_led        <= 1'b0;
      r_time_valid <= 1'b0;
      r_early      <= 1'b0;
      r_timeout    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
      case (r_state)
        ST_IDLE, ST_RESULT: begin
          if (start) begin
            r_state      <= ST_WAIT;
            r_busy       <= 1'b1;
            r_delay      <= w_delay_load;
            r_count      <= '0;
            r_time_ms    <= '0;
            r_time_valid <= 1'b0;
            r_early      <= 1'b0;
            r_timeout    <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (stop) begin
            r_state   <= ST_RESULT;
            r_busy    <= 1'b0;
            r_led     <= 1'b0;
            r_early   <= 1'b1;
            r_time_ms <= '0;
            r_delay   <= '0;
          end else if (w_tick) begin
            if (w_delay_done) begin
              r_state <= ST_LIGHT;
              r_led   <= 1'b1;
              r_delay <= '0;
              r_count <= '0;
            end else begin
              r_delay <= r_delay - 1'b1;
            end
          end
        end
        ST_LIGHT: begin
          // stop outranks a coincident tick, so the pre-increment count is kept
          if (w_cap_en) begin
            r_state      <= ST_RESULT;
            r_busy       <= 1'b0;
            r_led        <= 1'b0;
            r_time_ms    <= r_count;
            r_time_valid <= 1'b1;
          end else if (w_tick) begin
            if (r_count + 1'b1 >= MAX_MS_W) begin
              r_state   <= ST_RESULT;
              r_busy    <= 1'b0;
              r_led     <= 1'b0;
              r_timeout <= 1'b1;
              r_time_ms <= MAX_MS_W;
              r_count   <= MAX_MS_W;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef REACTION_BEST_SCORE_EN
  logic [MS_W-1:0] r_best_ms;

  always_ff @(posedge clk) begin
    if (reset)                              r_best_ms <= MAX_MS_W;
    else if (w_cap_en && r_count < r_best_ms) r_best_ms <= r_count;
  end

  assign best_ms = r_best_ms;
`endif

  assign led        = r_led;
  assign time_ms    = r_time_ms;
  assign time_valid = r_time_valid;
  assign early      = r_early;
  assign timeout    = r_timeout;
  assign busy       = r_busy;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Scoreboard bench for reaction_timer_ctrl with a fast tick (TICK_DIV=4).
// Define REACTION_BEST_SCORE_EN to also check best_ms.
module tb_reaction_timer_ctrl;

  localparam int TICK_DIV = 4;
  localparam int MAX_MS   = 20;

  logic        clk, reset, start, stop;
  logic        led, time_valid, early, timeout, busy;
  logic [13:0] time_ms;
`ifdef REACTION_BEST_SCORE_EN
  logic [13:0] best_ms;
`endif

  reaction_timer_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .DELAY_MIN  (2),
    .DELAY_MASK (10'h000),
    .MAX_MS     (MAX_MS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .led        (led),
    .time_ms    (time_ms),
    .time_valid (time_valid),
    .early      (early),
    .timeout    (timeout),
    .busy       (busy)
`ifdef REACTION_BEST_SCORE_EN
    , .best_ms  (best_ms)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        early;
    logic        timeout;
    logic        valid;
    logic [13:0] ms;
  } res_t;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_best = MAX_MS;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic push_exp(input logic e, input logic t, input logic v, input int ms);
    res_t r;
    r.early = e; r.timeout = t; r.valid = v; r.ms = 14'(ms);
    exp_q.push_back(r);
    if (v && ms < exp_best) exp_best = ms;
  endtask

  // Edges from WAIT entry until led is seen; optionally pokes start mid-WAIT
  task automatic wait_led(output int n, input bit poke_start);
    n = 0;
    while (!led && n < 100) begin
      start = poke_start && (n == 3);
      step();
      n++;
    end
    start = 1'b0;
  endtask

  // stop is sampled on the n-th edge after led became visible
  task automatic stop_after(input int n);
    repeat (n - 1) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic get_result(input string tag);
    int   w;
    res_t r;
    w = 0;
    while (busy && w < 200) begin
      step();
      w++;
    end
    if (w >= 200) chk({tag, "_wait"}, 32'(w), 32'd0);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      r = exp_q.pop_front();
      chk({tag, "_early"},   32'(early),      32'(r.early));
      chk({tag, "_timeout"}, 32'(timeout),    32'(r.timeout));
      chk({tag, "_valid"},   32'(time_valid), 32'(r.valid));
      chk({tag, "_ms"},      32'(time_ms),    32'(r.ms));
      chk({tag, "_led"},     32'(led),        32'd0);
    end
  endtask

  int n;
  bit saw_led;

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();

    chk("rst_led",     32'(led),        32'd0);
    chk("rst_busy",    32'(busy),       32'd0);
    chk("rst_valid",   32'(time_valid), 32'd0);
    chk("rst_early",   32'(early),      32'd0);
    chk("rst_timeout", 32'(timeout),    32'd0);
    chk("rst_ms",      32'(time_ms),    32'd0);
`ifdef REACTION_BEST_SCORE_EN
    chk("rst_best",    32'(best_ms),    32'(MAX_MS));
`endif

    // normal round; a start inside WAIT must not restart the delay
    pulse_start();
    chk("busy_wait", 32'(busy), 32'd1);
    wait_led(n, 1'b1);
    chk("led_rise", 32'(n), 32'd8);
    push_exp(1'b0, 1'b0, 1'b1, 3);
    stop_after(13);
    get_result("normal");

    // RESULT holds, stop ignored
    repeat (3) step();
    stop = 1'b1; step(); stop = 1'b0;
    repeat (3) step();
    chk("hold_ms",    32'(time_ms),    32'd3);
    chk("hold_valid", 32'(time_valid), 32'd1);
    chk("hold_busy",  32'(busy),       32'd0);

    // early press 3 cycles after start
    pulse_start();
    saw_led = 1'b0;
    repeat (2) begin step(); saw_led |= led; end
    stop = 1'b1; step(); stop = 1'b0;
    saw_led |= led;
    push_exp(1'b1, 1'b0, 1'b0, 0);
    get_result("early");
    chk("early_no_led", 32'(saw_led), 32'd0);

    // stop on the delay-expiry edge: early wins
    pulse_start();
    repeat (7) step();
    stop = 1'b1; step(); stop = 1'b0;
    push_exp(1'b1, 1'b0, 1'b0, 0);
    get_result("early_win");
    repeat (10) step();
    chk("early_win_led", 32'(led), 32'd0);

    // stop coincident with the 3rd tick captures the pre-increment count
    pulse_start();
    wait_led(n, 1'b0);
    push_exp(1'b0, 1'b0, 1'b1, 2);
    stop_after(12);
    get_result("simul");

    // timeout
    pulse_start();
    wait_led(n, 1'b0);
    push_exp(1'b0, 1'b1, 1'b0, MAX_MS);
    n = 0;
    while (!timeout && n < 300) begin
      step();
      n++;
    end
    chk("timeout_lat", 32'(n), 32'd80);
    get_result("timeout");

    // reset mid-LIGHT
    pulse_start();
    wait_led(n, 1'b0);
    repeat (5) step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("mid_rst_led",   32'(led),     32'd0);
    chk("mid_rst_busy",  32'(busy),    32'd0);
    chk("mid_rst_early", 32'(early),   32'd0);
    chk("mid_rst_to",    32'(timeout), 32'd0);
    stop = 1'b1; step(); stop = 1'b0;
    repeat (10) step();
    chk("post_rst_valid", 32'(time_valid), 32'd0);
    chk("post_rst_ms",    32'(time_ms),    32'd0);
    chk("post_rst_busy",  32'(busy),       32'd0);
    exp_best = MAX_MS;
`ifdef REACTION_BEST_SCORE_EN
    chk("post_rst_best",  32'(best_ms),    32'(MAX_MS));
`endif

    // results 5, 3, 7
    foreach (exp_q[i]) exp_q.delete(i);
    for (int k = 0; k < 3; k++) begin
      int ms;
      ms = (k == 0) ? 5 : (k == 1) ? 3 : 7;
      pulse_start();
      wait_led(n, 1'b0);
      push_exp(1'b0, 1'b0, 1'b1, ms);
      stop_after(ms * TICK_DIV + 1);
      get_result("series");
`ifdef REACTION_BEST_SCORE_EN
      chk("best", 32'(best_ms), 32'(exp_best));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reaction_timer_ctrl.md
REACTION_TIMER_CTRL -- requirements
Module: reaction_timer_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000: clock cycles per 1 ms tick.
REQ-002 SHALL have parameter DELAY_MIN, default 1000: minimum random delay in ms.
REQ-003 SHALL have parameter DELAY_MASK, default 10'h3FF: mask applied to the LFSR value added to the delay.
REQ-004 SHALL have parameter MAX_MS, default 9999: timeout limit in ms.
REQ-005 SHALL have port clk, input, 1: clock, all logic on the rising edge.
REQ-006 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port start, input, 1: single-cycle start pulse, already synchronised and debounced.
REQ-008 SHALL have port stop, input, 1: single-cycle player-response pulse, already synchronised and debounced.
REQ-009 SHALL have port led, output, 1: stimulus light.
REQ-010 SHALL have port time_ms, output, 14: measured reaction time in ms.
REQ-011 SHALL have port time_valid, output, 1: time_ms holds a valid measurement.
REQ-012 SHALL have port early, output, 1: stop arrived before led.
REQ-013 SHALL have port timeout, output, 1: no stop arrived within MAX_MS.
REQ-014 SHALL have port busy, output, 1: high in WAIT and LIGHT.

Function
REQ-015 SHALL implement four states: IDLE, WAIT, LIGHT and RESULT; all outputs are registered.
REQ-016 SHALL use a 10-bit LFSR, polynomial x^10+x^7+1, that advances every cycle.
REQ-017 On start in IDLE or RESULT, SHALL go to WAIT.
- Load delay = DELAY_MIN + (lfsr & DELAY_MASK).
- Clear time_valid, early, timeout and time_ms.
REQ-018 SHALL generate a ms tick with a prescaler that counts 0..TICK_DIV-1 and ticks at TICK_DIV-1.
- The prescaler clears on entry to WAIT and to LIGHT, so the first tick comes exactly TICK_DIV cycles after entry.
REQ-019 In WAIT, each tick SHALL decrement delay.
- On the tick where delay reaches 0: go to LIGHT, set led=1, clear the ms counter.
REQ-020 In WAIT, stop SHALL go to RESULT with early=1, time_ms=0, led=0.
- stop on the same cycle as delay expiry: early wins.
REQ-021 In LIGHT, each tick SHALL increment the ms counter.
- On stop: go to RESULT, led=0, time_ms=counter, time_valid=1.
- stop coincident with a tick captures the pre-increment value.
REQ-022 In LIGHT, the counter reaching MAX_MS SHALL go to RESULT with timeout=1, time_ms=MAX_MS, led=0.
REQ-023 Visibility timing:
- Result flags SHALL be visible the cycle after the capturing edge.
- RESULT SHALL hold all outputs until the next start.
REQ-024 start in WAIT or LIGHT SHALL be ignored; stop in IDLE or RESULT SHALL be ignored.
REQ-025 The result register SHALL load only when its enable is asserted, on the capture cycle.

Reset
REQ-026 On reset, SHALL set:
- state=IDLE;
- led, time_valid, early, timeout and busy = 0;
- time_ms=0;
- lfsr=10'h3FF;
- prescaler, delay and counter = 0.
REQ-027 reset SHALL override start and stop in any state, including mid-WAIT and mid-LIGHT.

Configuration
REQ-028 With REACTION_BEST_SCORE_EN defined, SHALL add output best_ms [13:0].
- best_ms resets to MAX_MS.
- best_ms loads time_ms on any valid result strictly less than the current best.
REQ-029 Without REACTION_BEST_SCORE_EN, SHALL omit the best_ms port and its register entirely.

Structure
REQ-030 SHALL take the state enum, MS_W=14 and the LFSR tap constants from shared package reaction_pkg.
REQ-031 SHALL instantiate the prescaler as sub-module ms_tick_gen, with ports clk, reset, clear, tick.

Verification (TICK_DIV=4, DELAY_MIN=2, DELAY_MASK=0, MAX_MS=20)
REQ-032 Normal round: start; led rises 8 cycles after WAIT entry; stop 13 cycles after led rises -> time_ms=3, time_valid=1, led=0.
REQ-033 Early press: stop 3 cycles after start -> early=1, time_ms=0, led never high.
REQ-034 Timeout: no stop -> 80 cycles after LIGHT entry timeout=1, time_ms=20, led=0.
REQ-035 Simultaneous events: stop on the 3rd tick cycle -> time_ms=2.
REQ-036 Reset mid-LIGHT: all outputs return to 0, state IDLE, a following stop is ignored.
REQ-037 With REACTION_BEST_SCORE_EN, results 5, 3, 7 -> best_ms reads 5, 3, 3.
